uiip_type_demux: RTL and testbench

//  Parametrised EtherType demultiplexer for the uiudp stack RX path; sits between MAC RX and the IP/ARP/other protocol RX engines.

---
 rtl/uiip_pkg.sv | 25 ++
 rtl/uiip_type_match.sv | 37 +++
 rtl/uiip_type_demux.sv | 164 ++++++++++++++++
 tb/tb_uiip_type_demux.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uiip_pkg.sv
// ---------------------------------------------------------------------------
// uiip_pkg
// Shared definitions for the uiudp RX path:
//   - well-known EtherType values used to build the default type table
//   - FSM state encoding of the EtherType demultiplexer
// ---------------------------------------------------------------------------
package uiip_pkg;

    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

    // S_WAIT : waiting for the tail of a frame that was cut by reset
    // S_IDLE : between frames, next valid beat is classified
    // S_PASS : forwarding the current frame on the latched channel
    // S_DROP : discarding the current (unmatched) frame
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_IDLE = 2'd1,
        S_PASS = 2'd2,
        S_DROP = 2'd3
    } demux_state_t;

endpackage : uiip_pkg

// File: rtl/uiip_type_match.sv
// ---------------------------------------------------------------------------
// uiip_type_match
// Combinational EtherType table lookup. All CH_NUM entries are compared in
// parallel; when several entries match, the lowest index wins, so a
// higher-index duplicate entry can never be selected.
//
// Ports
//   i_type    in   16       EtherType to classify
//   o_hit     out  1        at least one table entry matches
//   o_ch_idx  out  IDX_W    lowest matching entry index (0 when no hit)
// ---------------------------------------------------------------------------
module uiip_type_match #(
    parameter int                   CH_NUM   = 4,
    parameter int                   IDX_W    = 2,
    parameter logic [16*CH_NUM-1:0] TYPE_TAB = '0
) (
    input  logic [15:0]      i_type,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_ch_idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a
        // no-match path would leave it unassigned and infer a latch.
        o_hit    = 1'b0;
        o_ch_idx = '0;
        // Scan from the top down so the last assignment, i.e. the lowest
        // matching index, is the one that sticks.
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (i_type == TYPE_TAB[16*i +: 16]) begin
                o_hit    = 1'b1;
                o_ch_idx = IDX_W'(i);
            end
        end
    end

endmodule : uiip_type_match

// File: rtl/uiip_type_demux.sv
// ---------------------------------------------------------------------------
// uiip_type_demux
// EtherType demultiplexer between MAC RX and the protocol RX engines.
// A frame is classified once, on its first valid beat, and its channel is
// held until I_mac_rvalid drops. Matching frames are forwarded with a fixed
// 2-cycle latency and frame-last marking; unmatched frames are dropped.
//
// Configuration macro: UIIP_DEMUX_STATS_EN
//   defined     -> saturating 16-bit accepted/dropped frame counters
//   not defined -> counter logic removed, O_drop_cnt/O_frame_cnt read 0
//
// Ports
//   I_eth_rclk        in   1       RX clock, rising edge
//   I_eth_reset_n     in   1       asynchronous active-low reset
//   I_mac_rvalid      in   1       MAC beat valid (one high run per frame)
//   I_mac_rdata       in   DATA_W  MAC beat data
//   I_mac_rdata_type  in   16      EtherType, used on the first beat only
//   O_ch_rvalid       out  CH_NUM  one-hot channel beat valid
//   O_ch_rdata        out  DATA_W  shared data bus, 0 when no valid
//   O_ch_rlast        out  1       last beat of frame, qualified by valid
//   O_drop_cnt        out  16      unmatched-frame count (stats build)
//   O_frame_cnt       out  16      accepted-frame count (stats build)
// ---------------------------------------------------------------------------
module uiip_type_demux
    import uiip_pkg::*;
#(
    parameter int                   DATA_W   = 8,
    parameter int                   CH_NUM   = 4,
    parameter logic [16*CH_NUM-1:0] TYPE_TAB = {ETH_TYPE_VLAN, ETH_TYPE_IPV6,
                                                ETH_TYPE_ARP,  ETH_TYPE_IP}
) (
    input  logic              I_eth_rclk,
    input  logic              I_eth_reset_n,
    input  logic              I_mac_rvalid,
    input  logic [DATA_W-1:0] I_mac_rdata,
    input  logic [15:0]       I_mac_rdata_type,
    output logic [CH_NUM-1:0] O_ch_rvalid,
    output logic [DATA_W-1:0] O_ch_rdata,
    output logic              O_ch_rlast,
    output logic [15:0]       O_drop_cnt,
    output logic [15:0]       O_frame_cnt
);

    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    demux_state_t      r_state;
    logic [IDX_W-1:0]  r_ch_idx;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [IDX_W-1:0]  r_s1_idx;

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_classify;
    logic              w_pass_beat;
    logic [IDX_W-1:0]  w_pass_idx;
    logic              w_frame_cont;
    logic [CH_NUM-1:0] w_s1_onehot;

    uiip_type_match #(
        .CH_NUM   (CH_NUM),
        .IDX_W    (IDX_W),
        .TYPE_TAB (TYPE_TAB)
    ) u_type_match (
        .i_type   (I_mac_rdata_type),
        .o_hit    (w_hit),
        .o_ch_idx (w_idx)
    );

    // First beat of a frame, seen while idle.
    assign w_classify   = (r_state == S_IDLE) && I_mac_rvalid;
    // Beat that goes down the pipeline: a matching first beat, or any beat
    // of a frame already locked to a channel.
    assign w_pass_beat  = (w_classify && w_hit) ||
                          ((r_state == S_PASS) && I_mac_rvalid);
    assign w_pass_idx   = (r_state == S_PASS) ? r_ch_idx : w_idx;
    // The input beat continues the frame held in stage1. A new frame can
    // never directly follow in S_PASS because the MAC leaves a gap.
    assign w_frame_cont = (r_state == S_PASS) && I_mac_rvalid;

    always_comb begin
        w_s1_onehot           = '0;
        w_s1_onehot[r_s1_idx] = 1'b1;
    end

    // Frame-level FSM; the channel is latched only on the classify cycle so
    // later type changes inside the frame have no effect.
    always_ff @(posedge I_eth_rclk or negedge I_eth_reset_n) begin
        if (!I_eth_reset_n) begin
            r_state  <= S_WAIT;
            r_ch_idx <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from pre-edge values regardless of order.
            case (r_state)
                S_WAIT: if (!I_mac_rvalid) r_state <= S_IDLE;
                S_IDLE: begin
                    if (I_mac_rvalid) begin
                        if (w_hit) begin
                            r_state  <= S_PASS;
                            r_ch_idx <= w_idx;
                        end else begin
                            r_state  <= S_DROP;
                        end
                    end
                end
                S_PASS: if (!I_mac_rvalid) r_state <= S_IDLE;
                S_DROP: if (!I_mac_rvalid) r_state <= S_IDLE;
                default: r_state <= S_WAIT;
            endcase
        end
    end

    // Two-stage pipeline. Stage1 holds one pass beat; the output stage
    // decides last by looking at the beat now arriving behind it.
    always_ff @(posedge I_eth_rclk or negedge I_eth_reset_n) begin
        if (!I_eth_reset_n) begin
            // NOTE: data registers are reset as well as valids, because the
            // shared data bus must read 0 whenever no channel is valid.
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_idx    <= '0;
            O_ch_rvalid <= '0;
            O_ch_rdata  <= '0;
            O_ch_rlast  <= 1'b0;
        end else begin
            r_s1_valid <= w_pass_beat;
            r_s1_idx   <= w_pass_idx;
            if (w_pass_beat) begin
                r_s1_data <= I_mac_rdata;
            end
            O_ch_rvalid <= r_s1_valid ? w_s1_onehot : '0;
            O_ch_rdata  <= r_s1_valid ? r_s1_data : '0;
            O_ch_rlast  <= r_s1_valid && !w_frame_cont;
        end
    end

`ifdef UIIP_DEMUX_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_frame_cnt;

    // Saturating counters, bumped on the classify cycle.
    always_ff @(posedge I_eth_rclk or negedge I_eth_reset_n) begin
        if (!I_eth_reset_n) begin
            r_drop_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (w_classify) begin
            if (w_hit) begin
                if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign O_drop_cnt  = r_drop_cnt;
    assign O_frame_cnt = r_frame_cnt;
`else
    assign O_drop_cnt  = 16'd0;
    assign O_frame_cnt = 16'd0;
`endif

endmodule : uiip_type_demux

// File: tb/tb_uiip_type_demux.sv
// ---------------------------------------------------------------------------
// tb_uiip_type_demux
// Frame-level reference model: each driven frame is classified against the
// type table by its first-beat EtherType, and, when it matches, its beats
// are scheduled as expected outputs 2 cycles after they are driven. A
// negedge monitor compares every cycle against that schedule.
// Build with +define+UIIP_DEMUX_STATS_EN to exercise the counters.
// ---------------------------------------------------------------------------
module tb_uiip_type_demux;

    localparam int DATA_W = 8;
    localparam int CH_NUM = 4;
    localparam logic [16*CH_NUM-1:0] TAB = {16'h8100, 16'h86DD, 16'h0806, 16'h0800};
`ifdef UIIP_DEMUX_STATS_EN
    localparam int TIMEOUT_CYC = 300000;
`else
    localparam int TIMEOUT_CYC = 20000;
`endif

    logic              I_eth_rclk = 1'b0;
    logic              I_eth_reset_n;
    logic              I_mac_rvalid;
    logic [DATA_W-1:0] I_mac_rdata;
    logic [15:0]       I_mac_rdata_type;
    logic [CH_NUM-1:0] O_ch_rvalid;
    logic [DATA_W-1:0] O_ch_rdata;
    logic              O_ch_rlast;
    logic [15:0]       O_drop_cnt;
    logic [15:0]       O_frame_cnt;

    uiip_type_demux #(
        .DATA_W   (DATA_W),
        .CH_NUM   (CH_NUM),
        .TYPE_TAB (TAB)
    ) dut (
        .I_eth_rclk       (I_eth_rclk),
        .I_eth_reset_n    (I_eth_reset_n),
        .I_mac_rvalid     (I_mac_rvalid),
        .I_mac_rdata      (I_mac_rdata),
        .I_mac_rdata_type (I_mac_rdata_type),
        .O_ch_rvalid      (O_ch_rvalid),
        .O_ch_rdata       (O_ch_rdata),
        .O_ch_rlast       (O_ch_rlast),
        .O_drop_cnt       (O_drop_cnt),
        .O_frame_cnt      (O_frame_cnt)
    );

    always #5 I_eth_rclk = ~I_eth_rclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Expected output schedule, keyed by cycle number.
    logic [CH_NUM-1:0] exp_v [int];
    logic [DATA_W-1:0] exp_d [int];
    logic              exp_l [int];

    logic [DATA_W-1:0] beat_q [$];
    logic [15:0]       m_frames = 16'd0;
    logic [15:0]       m_drops  = 16'd0;

    always @(posedge I_eth_rclk) cyc = cyc + 1;

    function automatic int model_channel(input logic [15:0] t);
        for (int i = 0; i < CH_NUM; i++)
            if (t == TAB[16*i +: 16]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    function automatic logic [15:0] exp_frame_cnt();
`ifdef UIIP_DEMUX_STATS_EN
        return m_frames;
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_drop_cnt();
`ifdef UIIP_DEMUX_STATS_EN
        return m_drops;
`else
        return 16'd0;
`endif
    endfunction

    // Cycle-by-cycle output monitor.
    always @(negedge I_eth_rclk) begin
        if (mon_en) begin
            logic [CH_NUM-1:0] ev;
            logic [DATA_W-1:0] ed;
            logic              el;
            ev = exp_v.exists(cyc) ? exp_v[cyc] : '0;
            ed = exp_d.exists(cyc) ? exp_d[cyc] : '0;
            el = exp_l.exists(cyc) ? exp_l[cyc] : 1'b0;
            checks++;
            if (O_ch_rvalid !== ev || O_ch_rdata !== ed ||
                (ev != '0 && O_ch_rlast !== el)) begin
                errors++;
                $display("FAIL beat cyc=%0d: got valid=%b data=%h last=%b, want valid=%b data=%h last=%b",
                         cyc, O_ch_rvalid, O_ch_rdata, O_ch_rlast, ev, ed, el);
            end
            exp_v.delete(cyc);
            exp_d.delete(cyc);
            exp_l.delete(cyc);
`ifndef UIIP_DEMUX_STATS_EN
            checks++;
            if (O_drop_cnt !== 16'd0 || O_frame_cnt !== 16'd0) begin
                errors++;
                $display("FAIL counters_tied cyc=%0d: got drop=%h frame=%h, want 0/0",
                         cyc, O_drop_cnt, O_frame_cnt);
            end
`endif
        end
    end

    task automatic step();
        @(posedge I_eth_rclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drives beat_q as one frame; type switches from t0 to t1 at beat sw.
    task automatic drive_frame(input logic [15:0] t0, input logic [15:0] t1, input int sw);
        int ch;
        int n;
        int base;
        logic [CH_NUM-1:0] oh;
        n  = beat_q.size();
        ch = model_channel(t0);
        oh = '0;
        if (ch >= 0) oh[ch] = 1'b1;
        step();
        base = cyc;
        if (ch >= 0) m_frames = sat_inc(m_frames);
        else         m_drops  = sat_inc(m_drops);
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            I_mac_rvalid     = 1'b1;
            I_mac_rdata      = beat_q[k];
            I_mac_rdata_type = (k >= sw) ? t1 : t0;
            if (ch >= 0) begin
                exp_v[base + k + 2] = oh;
                exp_d[base + k + 2] = beat_q[k];
                exp_l[base + k + 2] = (k == n - 1);
            end
        end
        step();
        I_mac_rvalid     = 1'b0;
        I_mac_rdata      = DATA_W'($urandom);
        I_mac_rdata_type = 16'($urandom);
    endtask

    task automatic purge_from(input int c);
        int keys [$];
        foreach (exp_v[k]) if (k >= c) keys.push_back(k);
        foreach (keys[i]) begin
            exp_v.delete(keys[i]);
            exp_d.delete(keys[i]);
            exp_l.delete(keys[i]);
        end
    endtask

    task automatic test_reset();
        I_eth_reset_n    = 1'b0;
        I_mac_rvalid     = 1'b0;
        I_mac_rdata      = '0;
        I_mac_rdata_type = '0;
        idle(3);
        checks++;
        if (O_ch_rvalid !== '0 || O_ch_rdata !== '0 || O_ch_rlast !== 1'b0 ||
            O_drop_cnt !== 16'd0 || O_frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h last=%b drop=%h frame=%h, want all 0",
                     O_ch_rvalid, O_ch_rdata, O_ch_rlast, O_drop_cnt, O_frame_cnt);
        end
        I_eth_reset_n = 1'b1;
        mon_en = 1'b1;
        idle(2);
    endtask

    task automatic test_ip_frame();
        beat_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_frame(16'h0800, 16'h0800, 4);
        idle(4);
        checks++;
        if (O_frame_cnt !== exp_frame_cnt() || O_drop_cnt !== exp_drop_cnt()) begin
            errors++;
            $display("FAIL ip_frame_cnt: got frame=%h drop=%h, want frame=%h drop=%h",
                     O_frame_cnt, O_drop_cnt, exp_frame_cnt(), exp_drop_cnt());
        end
    endtask

    task automatic test_single_beat();
        beat_q = '{8'hAA};
        drive_frame(16'h0806, 16'h0806, 1);
        idle(3);
        beat_q = '{8'h5C};
        drive_frame(16'h8100, 16'h8100, 1);
        idle(3);
        checks++;
        if (O_frame_cnt !== exp_frame_cnt()) begin
            errors++;
            $display("FAIL single_beat_cnt: got frame=%h, want %h", O_frame_cnt, exp_frame_cnt());
        end
    endtask

    task automatic test_drop();
        logic [15:0] frames_before;
        frames_before = O_frame_cnt;
        beat_q = '{8'h01, 8'h02, 8'h03};
        drive_frame(16'h88CC, 16'h88CC, 3);
        idle(4);
        checks++;
        if (O_drop_cnt !== exp_drop_cnt() || O_frame_cnt !== frames_before) begin
            errors++;
            $display("FAIL drop_cnt: got drop=%h frame=%h, want drop=%h frame=%h",
                     O_drop_cnt, O_frame_cnt, exp_drop_cnt(), frames_before);
        end
    endtask

    task automatic test_type_switch();
        beat_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        drive_frame(16'h0800, 16'h0806, 2);
        idle(3);
        // Unmatched first beat, matching type later: whole frame dropped.
        beat_q = '{8'hB0, 8'hB1, 8'hB2};
        drive_frame(16'h1234, 16'h0800, 1);
        idle(3);
        checks++;
        if (O_frame_cnt !== exp_frame_cnt() || O_drop_cnt !== exp_drop_cnt()) begin
            errors++;
            $display("FAIL type_switch_cnt: got frame=%h drop=%h, want frame=%h drop=%h",
                     O_frame_cnt, O_drop_cnt, exp_frame_cnt(), exp_drop_cnt());
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        beat_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        step();
        base = cyc;
        m_frames = sat_inc(m_frames);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            I_mac_rvalid     = 1'b1;
            I_mac_rdata      = beat_q[k];
            I_mac_rdata_type = 16'h0800;
            if (k < 2) begin
                exp_v[base + k + 2] = 4'b0001;
                exp_d[base + k + 2] = beat_q[k];
                exp_l[base + k + 2] = 1'b0;
            end
            if (k == 2) begin
                I_eth_reset_n = 1'b0;
                purge_from(cyc);
                m_frames = 16'd0;
                m_drops  = 16'd0;
                #1;
                checks++;
                if (O_ch_rvalid !== '0 || O_ch_rdata !== '0 || O_ch_rlast !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_assert: got valid=%b data=%h last=%b, want 0",
                             O_ch_rvalid, O_ch_rdata, O_ch_rlast);
                end
            end
            if (k == 3) I_eth_reset_n = 1'b1;
        end
        step();
        I_mac_rvalid = 1'b0;
        idle(3);
        checks++;
        if (O_frame_cnt !== 16'd0 || O_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_tail_cnt: got frame=%h drop=%h, want 0/0", O_frame_cnt, O_drop_cnt);
        end
        beat_q = '{8'hD1, 8'hD2, 8'hD3};
        drive_frame(16'h86DD, 16'h86DD, 3);
        idle(4);
        checks++;
        if (O_frame_cnt !== exp_frame_cnt()) begin
            errors++;
            $display("FAIL after_reset_cnt: got frame=%h, want %h", O_frame_cnt, exp_frame_cnt());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] types [6];
        types = '{16'h0800, 16'h0806, 16'h88CC, 16'h86DD, 16'h8100, 16'h0800};
        for (int f = 0; f < 6; f++) begin
            beat_q = {};
            for (int k = 0; k <= f % 3; k++) beat_q.push_back(DATA_W'($urandom));
            drive_frame(types[f], types[f], 8);
        end
        idle(4);
        checks++;
        if (O_frame_cnt !== exp_frame_cnt() || O_drop_cnt !== exp_drop_cnt()) begin
            errors++;
            $display("FAIL b2b_cnt: got frame=%h drop=%h, want frame=%h drop=%h",
                     O_frame_cnt, O_drop_cnt, exp_frame_cnt(), exp_drop_cnt());
        end
    endtask

    task automatic test_random();
        logic [15:0] t0;
        logic [15:0] t1;
        int n;
        for (int f = 0; f < 60; f++) begin
            int sel;
            sel = $urandom_range(0, 5);
            t0  = (sel < CH_NUM) ? TAB[16*sel +: 16] : 16'($urandom);
            t1  = 16'($urandom);
            n   = $urandom_range(1, 8);
            beat_q = {};
            for (int k = 0; k < n; k++) beat_q.push_back(DATA_W'($urandom));
            drive_frame(t0, t1, $urandom_range(1, 8));
            idle($urandom_range(0, 3));
        end
        idle(4);
        checks++;
        if (O_frame_cnt !== exp_frame_cnt() || O_drop_cnt !== exp_drop_cnt()) begin
            errors++;
            $display("FAIL random_cnt: got frame=%h drop=%h, want frame=%h drop=%h",
                     O_frame_cnt, O_drop_cnt, exp_frame_cnt(), exp_drop_cnt());
        end
    endtask

`ifdef UIIP_DEMUX_STATS_EN
    task automatic test_saturation();
        logic [15:0] frames_before;
        frames_before = O_frame_cnt;
        for (int f = 0; f < 65537; f++) begin
            beat_q = '{DATA_W'(f)};
            drive_frame(16'h88CC, 16'h88CC, 1);
        end
        idle(3);
        checks++;
        if (O_drop_cnt !== 16'hFFFF || O_drop_cnt !== m_drops || O_frame_cnt !== frames_before) begin
            errors++;
            $display("FAIL drop_saturate: got drop=%h frame=%h, want drop=ffff frame=%h",
                     O_drop_cnt, O_frame_cnt, frames_before);
        end
    endtask
`endif

    task automatic test_drain();
        idle(5);
        checks++;
        if (exp_v.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected beats never reached, want 0", exp_v.size());
        end
    endtask

    initial begin
        repeat (TIMEOUT_CYC) @(posedge I_eth_rclk);
        errors++;
        $display("FAIL watchdog: got %0d cycles without finishing, want fewer", TIMEOUT_CYC);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ip_frame();
        test_single_beat();
        test_drop();
        test_type_switch();
        test_reset_midframe();
        test_back_to_back();
        test_random();
`ifdef UIIP_DEMUX_STATS_EN
        test_saturation();
`endif
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uiip_type_demux
